// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_sequencer
//  Purpose  : Two-requester round-robin front end for a shared registered ALU.
//             Arbitrates between two datapath clients, copies the winner's
//             operands and opcode onto the ALU inputs, holds them across the
//             ALU's register cycle and its flag-settling cycle, then captures
//             result and flags and pulses a per-requester done.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   system clock, rising edge
//    reset        in   asynchronous active-high reset
//    req_0/req_1  in   level requests, sampled only while idle
//    a_k,b_k,op_k in   operands/opcode of requester k
//    alu_a/alu_b  out  ALU operand inputs (held while busy)
//    alu_op       out  ALU opcode (held while busy)
//    alu_out      in   ALU registered result
//    alu_flags    in   ALU flags {C,N,O,Z}
//    result       out  captured ALU result, held until next capture
//    flags        out  captured ALU flags, held until next capture
//    done_0/1     out  one-cycle pulse, result/flags valid for requester k
//    busy         out  high whenever an operation is in flight
//    grant        out  index of requester currently or last served
// ============================================================================
module alu_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_0,
  input  logic             req_1,
  input  logic [WIDTH-1:0] a_0,
  input  logic [WIDTH-1:0] b_0,
  input  logic [2:0]       op_0,
  input  logic [WIDTH-1:0] a_1,
  input  logic [WIDTH-1:0] b_1,
  input  logic [2:0]       op_1,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [3:0]       alu_flags,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             done_0,
  output logic             done_1,
  output logic             busy,
  output logic             grant
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] alu_a_q,  alu_a_d;
  logic [WIDTH-1:0] alu_b_q,  alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q,  flags_d;
  logic             done_0_q, done_0_d;
  logic             done_1_q, done_1_d;
  logic             grant_q,  grant_d;
  logic             last_q,   last_d;

  // Arbitration winner for the current cycle. A lone request wins outright;
  // on a tie the requester that was not served last wins.
  logic             win;

  always_comb begin : arbitrate
    win = req_1;
    if (req_0 && req_1) begin
      win = ~last_q;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin : next_state
    state_d  = state_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    result_d = result_q;
    flags_d  = flags_q;
    grant_d  = grant_q;
    last_d   = last_q;
    // done is a single-cycle pulse, so it defaults low every cycle
    done_0_d = 1'b0;
    done_1_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // ALU inputs only ever change here, on a grant edge; the requester is
        // free to change its own operands once the grant edge has passed.
        if (req_0 || req_1) begin
          state_d  = ST_ISSUE;
          grant_d  = win;
          alu_a_d  = win ? a_1  : a_0;
          alu_b_d  = win ? b_1  : b_0;
          alu_op_d = win ? op_1 : op_0;
        end
      end

      ST_ISSUE: begin
        // The ALU registers its result on this cycle's closing edge.
        state_d = ST_CAPTURE;
      end

      ST_CAPTURE: begin
        // Inputs are still held because the ALU's C and O flags decode from
        // the live opcode and operands rather than from its register.
        state_d  = ST_IDLE;
        result_d = alu_out;
        flags_d  = alu_flags;
        done_0_d = ~grant_q;
        done_1_d = grant_q;
        last_d   = grant_q;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin : regs
    if (reset) begin
      state_q  <= ST_IDLE;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= 3'b000;
      result_q <= '0;
      flags_q  <= 4'b0000;
      done_0_q <= 1'b0;
      done_1_q <= 1'b0;
      grant_q  <= 1'b0;
      // last starts at 1 so requester 0 wins the first tie
      last_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      done_0_q <= done_0_d;
      done_1_q <= done_1_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign alu_a  = alu_a_q;
  assign alu_b  = alu_b_q;
  assign alu_op = alu_op_q;
  assign result = result_q;
  assign flags  = flags_q;
  assign done_0 = done_0_q;
  assign done_1 = done_1_q;
  assign grant  = grant_q;
  assign busy   = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_sequencer
//  Purpose  : Self-checking bench for alu_sequencer. Hosts a behavioural model
//             of the shared registered ALU and checks directed scenarios plus
//             randomized operations against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_0 = 1'b0, req_1 = 1'b0;
  logic [7:0] a_0 = '0, b_0 = '0, a_1 = '0, b_1 = '0;
  logic [2:0] op_0 = '0, op_1 = '0;
  logic [7:0] alu_a, alu_b, alu_out, result;
  logic [2:0] alu_op;
  logic [3:0] alu_flags, flags;
  logic       done_0, done_1, busy, grant;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .req_0(req_0), .req_1(req_1),
    .a_0(a_0), .b_0(b_0), .op_0(op_0),
    .a_1(a_1), .b_1(b_1), .op_1(op_1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_flags(alu_flags),
    .result(result), .flags(flags),
    .done_0(done_0), .done_1(done_1),
    .busy(busy), .grant(grant)
  );

  // Reference: {C,N,O,Z,result} of one ALU operation.
  function automatic logic [11:0] ref_op(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
    logic [8:0] s;
    logic [7:0] r;
    logic       c, o;
    c = 1'b0; o = 1'b0; s = '0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8];
                  o = (a[7] == b[7]) && (r[7] != a[7]); end
      3'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[7:0]; c = s[8];
                  o = (a[7] != b[7]) && (r[7] != a[7]); end
      3'd2: r = a | b;
      3'd3: r = a & b;
      3'd4: r = ~a;
      3'd5: r = (a == b) ? 8'd1 : 8'd0;
      3'd6: r = a >> 1;
      default: r = a << 1;
    endcase
    return {c, r[7], o, (r == 8'd0), r};
  endfunction

  // Shared ALU model: result register is never reset; C/O decode live inputs.
  logic [7:0]  alu_reg = 8'hA5;
  logic [11:0] alu_live;
  always_comb alu_live = ref_op(alu_a, alu_b, alu_op);
  always @(posedge clk) alu_reg <= alu_live[7:0];
  assign alu_out   = alu_reg;
  assign alu_flags = {alu_live[11], alu_reg[7], alu_live[9], (alu_reg == 8'd0)};

  // Stimulus helper: called one negedge after the grant edge. Waits (bounded)
  // for done_k, returning elapsed negedges and observations; no judging here.
  task automatic wait_done(input bit k, input int start_busy,
                           output int cyc, output int busy_cnt, output int alu_chg,
                           output int overlap, output int wrong);
    logic [18:0] snap;
    bit hit;
    snap = {alu_a, alu_b, alu_op};
    cyc = 1; busy_cnt = start_busy; alu_chg = 0; overlap = 0; wrong = 0; hit = 0;
    while (!hit && cyc < 20) begin
      @(negedge clk);
      cyc++;
      busy_cnt += int'(busy);
      if ({alu_a, alu_b, alu_op} !== snap) alu_chg++;
      if (done_0 && done_1) overlap++;
      if ((k ? done_0 : done_1) === 1'b1) wrong++;
      if ((k ? done_1 : done_0) === 1'b1) hit = 1;
    end
    if (!hit) cyc = -1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({alu_a, alu_b, alu_op, result, flags, done_0, done_1, busy, grant} !== '0) begin
      failures++;
      $display("FAIL reset_hold got=%h exp=0",
               {alu_a, alu_b, alu_op, result, flags, done_0, done_1, busy, grant});
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({alu_a, alu_b, alu_op, result, flags, done_0, done_1, busy, grant} !== '0) begin
        failures++;
        $display("FAIL reset_idle cycle=%0d got=%h exp=0", i,
                 {alu_a, alu_b, alu_op, result, flags, done_0, done_1, busy, grant});
      end
    end
  endtask

  // One isolated operation by requester k, with operands scrambled after grant.
  task automatic test_single_op(input bit k, input logic [7:0] a, input logic [7:0] b,
                                input logic [2:0] op, input logic [7:0] exp_res,
                                input logic [3:0] exp_flags, input string name);
    int cyc, bc, chg, ovl, wrong;
    @(negedge clk);
    if (k) begin a_1 = a; b_1 = b; op_1 = op; req_1 = 1'b1; end
    else   begin a_0 = a; b_0 = b; op_0 = op; req_0 = 1'b1; end
    @(negedge clk);
    checks++;
    if ({grant, alu_a, alu_b, alu_op} !== {k, a, b, op}) begin
      failures++;
      $display("FAIL %s_issue got=%h exp=%h", name, {grant, alu_a, alu_b, alu_op}, {k, a, b, op});
    end
    if (k) begin req_1 = 1'b0; a_1 = ~a; b_1 = a; op_1 = ~op; end
    else   begin req_0 = 1'b0; a_0 = ~a; b_0 = a; op_0 = ~op; end
    wait_done(k, int'(busy), cyc, bc, chg, ovl, wrong);
    checks++;
    if (cyc != 3) begin failures++; $display("FAIL %s_latency got=%0d exp=3", name, cyc); end
    checks++;
    if (bc != 2) begin failures++; $display("FAIL %s_busy_cycles got=%0d exp=2", name, bc); end
    checks++;
    if (result !== exp_res) begin
      failures++; $display("FAIL %s_result got=%h exp=%h", name, result, exp_res);
    end
    checks++;
    if (flags !== exp_flags) begin
      failures++; $display("FAIL %s_flags got=%b exp=%b", name, flags, exp_flags);
    end
    checks++;
    if ({chg, ovl, wrong} != 0) begin
      failures++;
      $display("FAIL %s_hold alu_changes=%0d overlap=%0d wrong_done=%0d exp=0", name, chg, ovl, wrong);
    end
  endtask

  task automatic test_alternate();
    int t, n, prev, ovl;
    logic [7:0] er;
    logic [3:0] ef;
    t = 0; n = 0; prev = 0; ovl = 0;
    @(negedge clk);
    a_0 = 8'h55; b_0 = 8'h55; op_0 = 3'd5;
    a_1 = 8'hF0; b_1 = 8'h0F; op_1 = 3'd3;
    req_0 = 1'b1; req_1 = 1'b1;
    while (n < 4 && t < 40) begin
      @(negedge clk);
      t++;
      if (done_0 && done_1) ovl++;
      if (done_0 || done_1) begin
        er = (n % 2 == 0) ? 8'h01 : 8'h00;
        ef = (n % 2 == 0) ? 4'b0000 : 4'b0001;
        checks++;
        if ({done_1, grant} !== {2{1'(n % 2)}}) begin
          failures++; $display("FAIL alt_order op=%0d got=%b exp=%0d", n, {done_1, grant}, n % 2);
        end
        checks++;
        if ({result, flags} !== {er, ef}) begin
          failures++; $display("FAIL alt_value op=%0d got=%h exp=%h", n, {result, flags}, {er, ef});
        end
        checks++;
        if (t - prev != 3) begin
          failures++; $display("FAIL alt_spacing op=%0d got=%0d exp=3", n, t - prev);
        end
        prev = t;
        n++;
      end
    end
    req_0 = 1'b0; req_1 = 1'b0;
    checks++;
    if (n != 4 || ovl != 0) begin
      failures++; $display("FAIL alt_count got=%0d overlap=%0d exp=4/0", n, ovl);
    end
  endtask

  task automatic test_tie_after_1();
    int cyc, bc, chg, ovl, wrong;
    test_single_op(1'b1, 8'h12, 8'h40, 3'd2, 8'h52, 4'b0000, "tie_pre");
    // Now at the done_1 cycle: raise both together.
    a_0 = 8'h30; b_0 = 8'h0F; op_0 = 3'd0;
    a_1 = 8'h01; b_1 = 8'h03; op_1 = 3'd1;
    req_0 = 1'b1; req_1 = 1'b1;
    @(negedge clk);
    checks++;
    if ({grant, alu_a} !== {1'b0, 8'h30}) begin
      failures++; $display("FAIL tie_winner got=%h exp=%h", {grant, alu_a}, {1'b0, 8'h30});
    end
    req_0 = 1'b0; a_0 = 8'hFF; b_0 = 8'hFF; op_0 = 3'd1;
    wait_done(1'b0, int'(busy), cyc, bc, chg, ovl, wrong);
    checks++;
    if ({cyc, result, flags} !== {32'd3, 8'h3F, 4'b0000}) begin
      failures++; $display("FAIL tie_r0 got=%0d/%h/%b exp=3/3f/0000", cyc, result, flags);
    end
    // req_1 was still held and must be served next.
    @(negedge clk);
    checks++;
    if (grant !== 1'b1) begin failures++; $display("FAIL tie_then_r1 got=%b exp=1", grant); end
    req_1 = 1'b0;
    wait_done(1'b1, int'(busy), cyc, bc, chg, ovl, wrong);
    checks++;
    if ({cyc, result, flags} !== {32'd3, 8'hFE, 4'b1100}) begin
      failures++; $display("FAIL tie_r1 got=%0d/%h/%b exp=3/fe/1100", cyc, result, flags);
    end
  endtask

  task automatic test_reset_capture();
    int dn;
    dn = 0;
    @(negedge clk);
    a_0 = 8'h10; b_0 = 8'h20; op_0 = 3'd0; req_0 = 1'b1;
    @(negedge clk);
    req_0 = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL rc_in_capture got=%b exp=1", busy); end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({busy, result, flags, done_0, done_1, grant} !== '0) begin
      failures++;
      $display("FAIL rc_async got=%h exp=0", {busy, result, flags, done_0, done_1, grant});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dn += int'(done_0) + int'(done_1);
    end
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      dn += int'(done_0) + int'(done_1);
    end
    checks++;
    if (dn != 0 || result !== 8'h00) begin
      failures++; $display("FAIL rc_no_done got=%0d/%h exp=0/00", dn, result);
    end
    test_single_op(1'b0, 8'h81, 8'h00, 3'd7, 8'h02, 4'b0000, "rc_shl");
  endtask

  task automatic test_random();
    int cyc, bc, chg, ovl, wrong, mask;
    bit model_last, win;
    logic [7:0]  ra0, rb0, ra1, rb1;
    logic [2:0]  rop0, rop1;
    logic [11:0] exp;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    model_last = 1'b1;
    for (int it = 0; it < 40; it++) begin
      mask = (it == 0) ? 3 : int'($urandom_range(1, 3));
      ra0 = 8'($urandom); rb0 = 8'($urandom); rop0 = 3'($urandom);
      ra1 = 8'($urandom); rb1 = 8'($urandom); rop1 = 3'($urandom);
      @(negedge clk);
      a_0 = ra0; b_0 = rb0; op_0 = rop0; a_1 = ra1; b_1 = rb1; op_1 = rop1;
      req_0 = mask[0]; req_1 = mask[1];
      win = (mask == 3) ? ~model_last : (mask == 2);
      exp = win ? ref_op(ra1, rb1, rop1) : ref_op(ra0, rb0, rop0);
      @(negedge clk);
      checks++;
      if (grant !== win) begin
        failures++; $display("FAIL rand_grant it=%0d got=%b exp=%b", it, grant, win);
      end
      req_0 = 1'b0; req_1 = 1'b0;
      a_0 = 8'($urandom); a_1 = 8'($urandom); op_0 = 3'($urandom); op_1 = 3'($urandom);
      wait_done(win, int'(busy), cyc, bc, chg, ovl, wrong);
      checks++;
      if ({flags, result} !== exp || cyc != 3 || chg != 0 || wrong != 0) begin
        failures++;
        $display("FAIL rand_op it=%0d got=%h cyc=%0d chg=%0d wrong=%0d exp=%h cyc=3",
                 it, {flags, result}, cyc, chg, wrong, exp);
      end
      model_last = win;
    end
  endtask

  initial begin
    test_reset();
    test_single_op(1'b0, 8'h7F, 8'h01, 3'd0, 8'h80, 4'b0110, "add_r0");
    test_single_op(1'b1, 8'h00, 8'h01, 3'd1, 8'hFF, 4'b1100, "sub_r1");
    test_single_op(1'b1, 8'hFF, 8'h01, 3'd0, 8'h00, 4'b1001, "add_r1");
    test_alternate();
    test_tie_after_1();
    test_reset_capture();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
